// File: rtl/ins_enc_pkg.sv
// Shared definitions for the instruction encoder: format codes, FSM states,
// common RV32I opcodes and the per-format immediate width table.
package ins_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_SB   = 3'd3,
    FMT_UJ   = 3'd4,
    FMT_U    = 3'd5,
    FMT_BAD6 = 3'd6,
    FMT_BAD7 = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  // Signed immediate width carried by each format; 0 means no immediate.
  function automatic int unsigned imm_width(fmt_e f);
    case (f)
      FMT_I, FMT_S, FMT_SB: return 12;
      FMT_UJ, FMT_U:        return 20;
      default:              return 0;
    endcase
  endfunction

  // True when imm is representable as a w-bit two's-complement value.
  function automatic logic imm_fits(logic [31:0] imm, int unsigned w);
    logic [31:0] mask;
    logic [31:0] upper;
    if (w == 0) return 1'b1;
    mask  = 32'hFFFF_FFFF << (w - 1);
    upper = imm & mask;
    return (upper == 32'h0) || (upper == mask);
  endfunction

endpackage

// File: rtl/ins_field_pack.sv
// Combinational packer: instruction fields -> 32-bit R/I/S/SB/UJ/U word.
// Optional INS_ENC_RANGE_CHECK_EN: range_ok flags out-of-range immediates
// and illegal formats; without it range_ok is constant 1 and fmt 6-7 pack as R.
module ins_field_pack
  import ins_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  fmt_e fmt_sel;
  logic unused_imm_hi;

  assign fmt_sel       = fmt_e'(fmt);
  // Upper immediate bits only matter to the optional range check.
  assign unused_imm_hi = ^imm[31:20];

  // Select the bit layout for the format; fields a format does not use stay 0.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    word     = 32'h0;
    range_ok = 1'b1;
    case (fmt_sel)
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_SB:  word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
      FMT_UJ:  word = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
      FMT_U:   word = {imm[19:0], rd, opcode};
      default: word = {funct7, rs2, rs1, funct3, rd, opcode};
    endcase
`ifdef INS_ENC_RANGE_CHECK_EN
    range_ok = (fmt_sel != FMT_BAD6) && (fmt_sel != FMT_BAD7) &&
               imm_fits(imm, imm_width(fmt_sel));
`endif
  end

endmodule

// File: rtl/ins_encoder.sv
// Instruction encoder: accepts field beats, packs them and writes the words
// to consecutive instruction-memory addresses starting at base_addr.
// Optional INS_ENC_RANGE_CHECK_EN: rejected beats set the sticky err flag.
module ins_encoder
  import ins_enc_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 256,
  parameter int CW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [2:0]    fmt,
  input  logic [6:0]    opcode,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [31:0]   imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [CW-1:0] count_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          err_q;

  logic [31:0]   packed_word;
  logic          range_ok;
  logic          accept;
  logic          reject;
  logic          at_limit;

  ins_field_pack u_pack (
    .fmt      (fmt),
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7   (funct7),
    .imm      (imm),
    .word     (packed_word),
    .range_ok (range_ok)
  );

  // count never exceeds DEPTH, so equality is the saturation test.
  assign at_limit = (count_q == DEPTH_C);
  // start has priority: a beat presented with start is not taken.
  assign in_ready = (state_q == ST_RUN) && !start && !at_limit;
  assign accept   = in_valid && in_ready;
  assign reject   = !range_ok;

  // Next-state logic: run until the last beat or the word limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (start)
          state_d = ST_RUN;
        else if (accept && (in_last || (!reject && (count_q + 1'b1) == DEPTH_C)))
          state_d = ST_DONE;
        else if (at_limit)
          state_d = ST_DONE;
      end
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Pointer/count bookkeeping and the one-cycle write output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (start) begin
        ptr_q   <= base_addr;
        count_q <= '0;
        err_q   <= 1'b0;
      end else if (accept) begin
        if (reject) begin
          err_q <= 1'b1;
        end else begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= ptr_q;
          mem_wdata_q <= packed_word;
          ptr_q       <= ptr_q + AW'(4);
          count_q     <= count_q + 1'b1;
        end
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err       = err_q;
  assign busy      = (state_q == ST_RUN) || mem_we_q;
  assign done      = (state_q == ST_DONE);

endmodule
